// File: rtl/pipe_log_adder.sv
// Pipelined Brent-Kung parallel-prefix adder/subtractor with valid/ready
// handshaking on both sides. The prefix network (up-sweep then down-sweep)
// is cut into STAGES register stages. Levels are spread evenly across the
// stages, and any extra levels go to the earliest stages. The last stage
// forms the sum and the flags and registers them as the outputs.
module pipe_log_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int LOG2W     = $clog2(WIDTH);
    localparam int LEVELS    = 2 * LOG2W - 1;
    // Guards the division below so a bad STAGES reaches the $error and not a divide-by-zero.
    localparam int STG_SAFE  = (STAGES < 1) ? 1 : STAGES;
    localparam int LVL_BASE  = LEVELS / STG_SAFE;
    localparam int LVL_REM   = LEVELS % STG_SAFE;

    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipe_log_adder: WIDTH must be a power of two in 4..64");
    end
    if (STAGES < 1 || STAGES > LOG2W + 1) begin : g_bad_stages
        $error("pipe_log_adder: STAGES must be in 1..log2(WIDTH)+1");
    end

    // True when prefix level lv is the first level of some stage other than stage 0.
    function automatic bit starts_stage(input int lv);
        bit hit;
        hit = 1'b0;
        for (int s = 1; s < STG_SAFE; s++) begin
            if (s * LVL_BASE + ((s < LVL_REM) ? s : LVL_REM) == lv) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Span between a node and its partner at prefix level lv.
    function automatic int node_dist(input int lv);
        return (lv < LOG2W) ? (1 << lv) : (1 << (2 * LOG2W - 2 - lv));
    endfunction

    // True when bit i combines with bit i-node_dist(lv) at level lv.
    // The up-sweep builds the power-of-two group prefixes; the down-sweep fills in the rest.
    function automatic bit is_node(input int lv, input int i);
        int d;
        d = node_dist(lv);
        if (lv < LOG2W) begin
            return ((i + 1) % (2 * d)) == 0;
        end
        return (((i + 1) % (2 * d)) == d) && (i >= 2 * d);
    endfunction

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    // Subtraction is A + ~B + 1. The carry-in is folded into bit 0's generate,
    // so each prefix result G[i:0] is the carry out of bit i.
    logic [WIDTH-1:0] b_cond;
    logic [WIDTH-1:0] gen_vec;
    logic [WIDTH-1:0] prop_vec;
    logic             carry_in_eff;
    assign b_cond       = sub ? ~b : b;
    assign carry_in_eff = sub ? 1'b1 : cin;
    assign prop_vec     = a ^ b_cond;
    assign gen_vec      = (a & b_cond) | {{(WIDTH-1){1'b0}}, prop_vec[0] & carry_in_eff};

    genvar gl, gi;
    for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
        logic [WIDTH-1:0] g_cur, p_cur, x_cur;
        logic [WIDTH-1:0] g_next, p_next;
        logic [WIDTH-1:0] g_out, p_out, x_out;
        logic             c_cur, v_cur, c_out, v_out;

        if (gl == 0) begin : g_src_in
            assign g_cur = gen_vec;
            assign p_cur = prop_vec;
            assign x_cur = prop_vec;
            assign c_cur = carry_in_eff;
            assign v_cur = in_valid;
        end else begin : g_src_prev
            assign g_cur = g_lvl[gl-1].g_out;
            assign p_cur = g_lvl[gl-1].p_out;
            assign x_cur = g_lvl[gl-1].x_out;
            assign c_cur = g_lvl[gl-1].c_out;
            assign v_cur = g_lvl[gl-1].v_out;
        end

        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (is_node(gl, gi)) begin : g_op
                localparam int J = gi - node_dist(gl);
                assign g_next[gi] = g_cur[gi] | (p_cur[gi] & g_cur[J]);
                assign p_next[gi] = p_cur[gi] & p_cur[J];
            end else begin : g_pass
                assign g_next[gi] = g_cur[gi];
                assign p_next[gi] = p_cur[gi];
            end
        end

        if (starts_stage(gl + 1)) begin : g_reg
            // Stage boundary: all stages shift together whenever the output can advance.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    g_out <= '0;
                    p_out <= '0;
                    x_out <= '0;
                    c_out <= 1'b0;
                    v_out <= 1'b0;
                end else if (advance) begin
                    g_out <= g_next;
                    p_out <= p_next;
                    x_out <= x_cur;
                    c_out <= c_cur;
                    v_out <= v_cur;
                end
            end
        end else begin : g_wire
            assign g_out = g_next;
            assign p_out = p_next;
            assign x_out = x_cur;
            assign c_out = c_cur;
            assign v_out = v_cur;
        end
    end

    // The group propagate is not needed after the last level.
    logic unused_final_p;
    assign unused_final_p = ^g_lvl[LEVELS-1].p_out;

    logic [WIDTH-1:0] g_fin, x_fin, carry_vec, sum_next;
    logic             c_fin, v_fin;
    assign g_fin     = g_lvl[LEVELS-1].g_out;
    assign x_fin     = g_lvl[LEVELS-1].x_out;
    assign c_fin     = g_lvl[LEVELS-1].c_out;
    assign v_fin     = g_lvl[LEVELS-1].v_out;
    assign carry_vec = {g_fin[WIDTH-2:0], c_fin};
    assign sum_next  = x_fin ^ carry_vec;

    logic [WIDTH-1:0] sum_reg;
    logic             out_valid_reg, co_reg, ovf_reg, zero_reg;

    // Output stage: result fields only change when a valid beat lands, so they hold across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            co_reg        <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
        end else if (advance) begin
            out_valid_reg <= v_fin;
            if (v_fin) begin
                sum_reg  <= sum_next;
                co_reg   <= g_fin[WIDTH-1];
                ovf_reg  <= g_fin[WIDTH-1] ^ g_fin[WIDTH-2];
                zero_reg <= (sum_next == '0);
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign co        = co_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_pipe_log_adder.sv
// Scoreboard bench for pipe_log_adder. The stimulus pushes the expected
// results, computed with plain integer arithmetic. A negedge monitor pops
// and compares each consumed result. Two small extra instances cover the
// other widths and pipeline depths.
module tb_pipe_log_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, co, ovf, zero;
    logic [15:0] a, b, sum;

    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, co8, ovf8, zero8;
    logic [7:0]  a8, b8, sum8;
    logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32, co32, ovf32, zero32;
    logic [31:0] a32, b32, sum32;

    pipe_log_adder #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .ovf(ovf), .zero(zero)
    );

    pipe_log_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .co(co8), .ovf(ovf8), .zero(zero8)
    );

    pipe_log_adder #(.WIDTH(32), .STAGES(6)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .sum(sum32), .co(co32), .ovf(ovf32), .zero(zero32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic        co;
        logic        ovf;
        logic        zero;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_res = 0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc++;

    // Reference: integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb,
                                   input logic ci, input logic su);
        exp_t   e;
        longint ua, ub, us, sa, sb, ss;
        ua = longint'(aa);
        ub = longint'(bb);
        sa = longint'($signed(aa));
        sb = longint'($signed(bb));
        if (su) begin
            us = ua - ub + 65536;
            ss = sa - sb;
        end else begin
            us = ua + ub + longint'(ci);
            ss = sa + sb + longint'(ci);
        end
        e.a       = aa;
        e.b       = bb;
        e.sub     = su;
        e.sum     = us[15:0];
        e.co      = (us >= 65536);
        e.ovf     = (ss > 32767) || (ss < -32768);
        e.zero    = (us[15:0] == 16'h0000);
        e.cyc     = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the beat has been accepted.
    task automatic send(input logic [15:0] aa, input logic [15:0] bb,
                        input logic ci, input logic su, input bit lat);
        exp_t e;
        bit   done;
        done     = 1'b0;
        a        = aa;
        b        = bb;
        cin      = ci;
        sub      = su;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e         = model(aa, bb, ci, su);
                e.cyc     = cyc;
                e.chk_lat = lat;
                sbq.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no accept for a=%h b=%h, required accept within 200 cycles", aa, bb);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d results outstanding, required 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed result must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result: got sum=%h with nothing outstanding, required no output", sum);
                end else begin
                    e = sbq.pop_front();
                    n_res++;
                    if ({sum, co, ovf, zero} !== {e.sum, e.co, e.ovf, e.zero}) begin
                        failures++;
                        $display("FAIL result: a=%h b=%h sub=%b got sum=%h co=%b ovf=%b zero=%b required sum=%h co=%b ovf=%b zero=%b",
                                 e.a, e.b, e.sub, sum, co, ovf, zero, e.sum, e.co, e.ovf, e.zero);
                    end else begin
                        $display("result a=%h b=%h sub=%b sum=%h co=%b ovf=%b zero=%b",
                                 e.a, e.b, e.sub, sum, co, ovf, zero);
                    end
                    if (e.chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
                end
            end
        end
    end

    // Random backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Watchdog in case a DUT event never arrives.
    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got no finish, required finish before 1 ms");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n_before, lat, found;
        logic [18:0] held;
        logic [15:0] ra, rb;
        bit          seen;

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_flags", {sum, co, ovf, zero}, 0);
        check("reset_alt_valid", {out_valid8, out_valid32}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 1);

        // Directed vectors, no backpressure: each must arrive exactly two cycles after accept.
        send(16'hFF00, 16'h00FF, 1'b0, 1'b0, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        send(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        send(16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1);
        send(16'h0000, 16'h0001, 1'b1, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        send(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1);
        wait_drain();

        // WIDTH=8, STAGES=1: 0xFF + 0x01.
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        @(negedge clk);
        check("alt8_in_ready", in_ready8, 1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        found = 0; lat = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            @(negedge clk);
            if (out_valid8) begin found = 1; lat = k; end
        end
        check("alt8_latency", 64'(lat), 64'd1);
        check("alt8_result", {sum8, co8, ovf8, zero8}, {8'h00, 1'b1, 1'b0, 1'b1});
        @(posedge clk);
        #1;

        // WIDTH=32, STAGES=6: 0x7FFFFFFF + 1.
        a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b0; in_valid32 = 1'b1;
        @(negedge clk);
        check("alt32_in_ready", in_ready32, 1);
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        found = 0; lat = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            @(negedge clk);
            if (out_valid32) begin found = 1; lat = k; end
        end
        check("alt32_latency", 64'(lat), 64'd6);
        check("alt32_result", {sum32, co32, ovf32, zero32}, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
        @(posedge clk);
        #1;

        // Backpressure: 5 back-to-back beats, out_ready low for 4 cycles after the first result.
        n_before = n_res;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                end
            end
            begin
                seen = 1'b0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1'b1;
                end
                check("bp_first_result", seen, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = {sum, co, ovf, zero};
                check("bp_in_ready_drop", in_ready, 0);
                check("bp_out_valid_held", out_valid, 1);
                repeat (3) begin
                    @(negedge clk);
                    check("bp_outputs_stable", {sum, co, ovf, zero}, held);
                    check("bp_in_ready_low", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_result_count", 64'(n_res - n_before), 64'd5);

        // Random operands, random bubbles and random backpressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 150; t++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = 16'hFFFF;
                2: rb = 16'h8000;
                3: ra = 16'h7FFF;
                default: ;
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Reset with two beats in flight; out_ready held low so neither is consumed.
        out_ready = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0);
        #3;
        check("pre_reset_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_sum", {sum, co, ovf, zero}, 0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        found = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) found++;
        end
        check("no_stale_after_reset", 64'(found), 64'd0);
        @(posedge clk);
        #1;
        send(16'h4321, 16'h1234, 1'b0, 1'b1, 1'b1);
        wait_drain();

        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
